alu_nibble_seq: RTL and testbench

Operand sequencer and result collector placed around the 4-bit alu.
- Accepts a wide operation (NIBBLES x 4 bits) over a valid/ready handshake.
- Feeds the alu one nibble per cycle, LSB nibble first, chaining alu co back into alu ci.
- Assembles the returned nibbles into a wide result, presented on a second valid/ready handshake.
- Upstream of the alu for operands and select; downstream of the alu for out/co.

---
 rtl/alu_nibble_seq.sv | 149 ++++++++++++++
 tb/tb_alu_nibble_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq
//   Serialises a wide add (NIBBLES x 4 bits) through the external 4-bit alu.
//   The alu sees one nibble per cycle, starting with the LSB nibble. Its carry
//   out is fed back as the carry in for the next nibble. The returned nibbles
//   are assembled into a wide result, which is presented on a valid/ready
//   handshake.
//
//   Optional feature:
//   Defining ALU_NIBBLE_SEQ_OVF_EN adds the res_ovf output. This is the
//   two's-complement overflow flag, captured together with res_co.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for an operation, in_ready=1, alu inputs forced to 0
//   RUN    | one nibble per cycle through the alu, idx selects the nibble
//   DONE   | result presented, held until res_ready
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_ci,
    input  logic                   in_s,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_ci,
    output logic                   alu_s,
    input  logic [3:0]             alu_out,
    input  logic                   alu_co,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_data,
    output logic                   res_co
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    ,
    output logic                   res_ovf
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_s;
    logic          r_res_valid;
    logic [W-1:0]  r_res_data;
    logic          r_res_co;
    logic          r_res_ovf;

    logic [IW+1:0] w_bit_ofs;
    logic          w_ovf;

    // Bit offset of the current nibble (idx * 4).
    assign w_bit_ofs = {r_idx, 2'b00};

    // Overflow: the operand signs are equal, but the sign of the result
    // differs from them. On the last RUN nibble, alu_out[3] is the result MSB.
    assign w_ovf = r_s && (r_a[W-1] == r_b[W-1]) && (alu_out[3] != r_a[W-1]);

    assign in_ready  = (r_state == S_IDLE);
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_co    = r_res_co;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    assign res_ovf   = r_res_ovf;
`endif

    // Drive the alu with the current nibble while in RUN, otherwise with zeros.
    always_comb begin
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_ci = 1'b0;
        alu_s  = 1'b0;
        if (r_state == S_RUN) begin
            alu_a  = r_a[w_bit_ofs +: 4];
            alu_b  = r_b[w_bit_ofs +: 4];
            alu_ci = r_carry;
            alu_s  = r_s;
        end
    end

    // Sequencer FSM: captures operands, walks the nibbles, collects the result.
    // The operand registers are left out of the reset because nothing reads
    // them outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_co    <= 1'b0;
            r_res_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_s     <= in_s;
                        r_carry <= in_ci;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res_data[w_bit_ofs +: 4] <= alu_out;
                    r_carry                    <= alu_co;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_res_co    <= alu_co;
                        r_res_ovf   <= w_ovf;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifndef ALU_NIBBLE_SEQ_OVF_EN
    // Without the overflow output, the flag has no reader.
    logic w_unused_ovf;
    assign w_unused_ovf = r_res_ovf;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Testbench for alu_nibble_seq with NIBBLES=4.
// The bench includes a behavioural model of the 4-bit alu.
// Expected results come from plain wide arithmetic on the operands.
module tb_alu_nibble_seq;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_ci, in_s;
    logic [3:0]   alu_a, alu_b;
    logic         alu_ci, alu_s;
    logic [3:0]   alu_out;
    logic         alu_co;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_co;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    logic         res_ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 4-bit alu: the carry chain is always active, and s gates the sum.
    logic [4:0] alu_sum;
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci};
    assign alu_out = alu_s ? alu_sum[3:0] : 4'd0;
    assign alu_co  = alu_sum[4];

    alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_s(in_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_s(alu_s),
        .alu_out(alu_out), .alu_co(alu_co),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_co(res_co)
`ifdef ALU_NIBBLE_SEQ_OVF_EN
        , .res_ovf(res_ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         s;
        logic [W-1:0] exp_data;
        logic         exp_co;
        logic         exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain wide addition.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic s, output logic [W-1:0] d, output logic co,
                         output logic ovf);
        logic [W:0] sum;
        logic [W-1:0] full;
        sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        full = sum[W-1:0];
        d    = s ? full : '0;
        co   = sum[W];
        ovf  = s && (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    endtask

    // Starts from a negedge with the DUT idle and ends at the negedge where
    // res_valid is first seen (the result is not yet taken).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            input logic s, output int lat, output int run_cyc,
                            output logic s_seen);
        in_a = a; in_b = b; in_ci = ci; in_s = s; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0; run_cyc = 0; s_seen = 1'b0;
        while (!res_valid && lat < 50) begin
            run_cyc++;
            s_seen = s_seen | alu_s;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!res_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: res_valid not seen after %0d cycles, expected 1", lat);
        end
    endtask

    // Completes the result handshake and checks that in_ready rises on the next cycle.
    task automatic take_result(input string name);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
        chk({name, "_valid_drop"}, {63'd0, res_valid}, 64'd0);
    endtask

    task automatic check_result(input string name, input logic [W-1:0] ed,
                                input logic eco, input logic eovf);
        chk({name, "_data"}, {48'd0, res_data}, {48'd0, ed});
        chk({name, "_co"}, {63'd0, res_co}, {63'd0, eco});
`ifdef ALU_NIBBLE_SEQ_OVF_EN
        chk({name, "_ovf"}, {63'd0, res_ovf}, {63'd0, eovf});
`else
        if (eovf === 1'bx) $display("unexpected x");
`endif
    endtask

    vec_t vecs[$];

    initial begin
        int lat, run_cyc;
        logic s_seen;
        logic [W-1:0] ra, rb, ed;
        logic rci, rs, eco, eovf;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; in_s = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_res_valid", {63'd0, res_valid}, 64'd0);
        chk("reset_res_data", {48'd0, res_data}, 64'd0);
        chk("reset_res_co", {63'd0, res_co}, 64'd0);
        chk("idle_alu_a", {60'd0, alu_a}, 64'd0);

        vecs.push_back('{16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, lat, run_cyc, s_seen);
            chk($sformatf("vec%0d_latency", i), lat, NIBBLES);
            chk($sformatf("vec%0d_run_cycles", i), run_cyc, NIBBLES);
            check_result($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_co, vecs[i].exp_ovf);
            if (!vecs[i].s)
                chk($sformatf("vec%0d_alu_s_zero", i), {63'd0, s_seen}, 64'd0);
            take_result($sformatf("vec%0d", i));
        end

        // Backpressure. New in_valid requests are ignored while DONE holds the result.
        res_ready = 1'b0;
        start_op(16'h1234, 16'h0FFF, 1'b0, 1'b1, lat, run_cyc, s_seen);
        in_a = 16'hAAAA; in_b = 16'h5555; in_ci = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_data", c), {48'd0, res_data}, 64'h2233);
            chk($sformatf("bp%0d_co", c), {63'd0, res_co}, 64'd0);
            chk($sformatf("bp%0d_valid", c), {63'd0, res_valid}, 64'd1);
            chk($sformatf("bp%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
        end
        take_result("bp");
        in_valid = 1'b0;

        // A reset pulse during the second RUN cycle drops the operation.
        in_a = 16'h00FF; in_b = 16'h0F01; in_ci = 1'b0; in_s = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_run_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_run_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_run_res_data", {48'd0, res_data}, 64'd0);
        start_op(16'h0001, 16'h0001, 1'b0, 1'b1, lat, run_cyc, s_seen);
        chk("after_rst_latency", lat, NIBBLES);
        check_result("after_rst", 16'h0002, 1'b0, 1'b0);
        take_result("after_rst");

        // Random operations, with random backpressure, checked against the model.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom); rb = W'($urandom);
            rci = 1'($urandom); rs = ($urandom_range(0, 3) != 0);
            model(ra, rb, rci, rs, ed, eco, eovf);
            res_ready = 1'b0;
            start_op(ra, rb, rci, rs, lat, run_cyc, s_seen);
            chk($sformatf("rnd%0d_latency", n), lat, NIBBLES);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                @(negedge clk);
            end
            check_result($sformatf("rnd%0d", n), ed, eco, eovf);
            take_result($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
